// File: rtl/fifo_read_stage.sv
// Read-side drain stage: pops a one-deep FIFO into a 2-entry skid buffer and
// presents the oldest entry over valid/ready. A redirect (JumpFlag) discards
// the buffered entries plus any FIFO entry and adds them to a saturating
// drop counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// EMPTY | no entry buffered; Head/Tail stale
// ONE   | Head holds the oldest (only) entry
// TWO   | Head holds the oldest entry, Tail the next; FIFO pops stop
module fifo_read_stage #(
  parameter int DataWidth = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DataWidth-1:0] FifoRData,
  input  logic                 FifoREmpty,
  output logic                 FifoRInc,
  output logic [DataWidth-1:0] OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  input  logic                 JumpFlag,
  output logic [7:0]           DropCnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } count_e;

  count_e               count_q, count_d;
  logic [DataWidth-1:0] head_q, head_d;
  logic [DataWidth-1:0] tail_q, tail_d;
  logic [7:0]           drop_q, drop_d;

  logic                 push;
  logic                 pop;
  logic [1:0]           count_bits;
  logic [8:0]           drop_sum;

  assign count_bits = count_q;

  // State registers; synchronous active-low reset clears everything,
  // overriding any flush or handshake in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and output decode. FifoRInc depends only on state, FIFO flag,
  // JumpFlag and reset, never on OutReady: a TWO->ONE pop only reopens the
  // FIFO read path one cycle later.
  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    drop_d   = drop_q;
    FifoRInc = 1'b0;
    OutValid = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    drop_sum = {1'b0, drop_q} + {7'd0, count_bits} + {8'd0, ~FifoREmpty};

    if (Rst) begin
      if (JumpFlag) begin
        FifoRInc = ~FifoREmpty;
      end else begin
        FifoRInc = ~FifoREmpty && (count_q != TWO);
      end
    end

    OutValid = (count_q != EMPTY) && !JumpFlag;
    push     = FifoRInc;
    pop      = OutValid && OutReady;

    if (JumpFlag) begin
      // Flush: buffered entries and the FIFO entry (popped this cycle) are lost.
      count_d = EMPTY;
      drop_d  = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end else begin
      unique case (count_q)
        EMPTY: begin
          if (push) begin
            count_d = ONE;
            head_d  = FifoRData;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = FifoRData;
          end else if (push) begin
            count_d = TWO;
            tail_d  = FifoRData;
          end else if (pop) begin
            count_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            count_d = ONE;
            head_d  = tail_q;
          end
        end
        default: begin
          count_d = EMPTY;
        end
      endcase
    end
  end

  assign OutData = head_q;
  assign DropCnt = drop_q;

endmodule

// File: tb/tb_fifo_read_stage.sv
// Bench for fifo_read_stage: a one-deep FIFO model feeds the stage; every
// entry written into the FIFO is queued as expected output, flushes empty the
// queue into an expected drop count, and a negedge monitor checks the outputs.
module tb_fifo_read_stage;
  localparam int DW = 64;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [DW-1:0] FifoRData;
  logic          FifoREmpty;
  logic          FifoRInc;
  logic [DW-1:0] OutData;
  logic          OutValid;
  logic          OutReady;
  logic          JumpFlag;
  logic [7:0]    DropCnt;

  int vectors = 0;
  int miscompares = 0;

  // FIFO model and scoreboard state
  logic          fifo_full;
  logic [DW-1:0] fifo_data;
  logic          winc_pend;
  logic [DW-1:0] wpend_data;
  logic          rinc_s;
  logic [DW-1:0] exp_q[$];
  int            exp_drop;
  int            exp_drop_nxt;
  bit            mon_en;

  assign FifoREmpty = !fifo_full;
  assign FifoRData  = fifo_data;

  fifo_read_stage #(.DataWidth(DW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .FifoRData  (FifoRData),
    .FifoREmpty (FifoREmpty),
    .FifoRInc   (FifoRInc),
    .OutData    (OutData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .JumpFlag   (JumpFlag),
    .DropCnt    (DropCnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // One clock cycle: apply the FIFO effects of the previous edge, drive new
  // inputs just after the edge, then sample the pop strobe at the negedge.
  task automatic step(input logic ready, input logic jump, input logic wr, input logic [DW-1:0] wd);
    @(posedge Clk); #1;
    if (rinc_s) fifo_full = 1'b0;
    if (winc_pend) begin
      fifo_full = 1'b1;
      fifo_data = wpend_data;
      exp_q.push_back(wpend_data);
    end
    exp_drop   = exp_drop_nxt;
    winc_pend  = wr && !fifo_full;
    wpend_data = wd;
    assert (!(winc_pend && fifo_full));
    OutReady = ready;
    JumpFlag = jump;
    if (jump) begin
      exp_drop_nxt = sat255(exp_drop + exp_q.size());
      exp_q.delete();
    end
    @(negedge Clk);
    rinc_s = FifoRInc;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic ready);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step(ready, 1'b0, 1'b1, d);
      done = winc_pend;
    end
    if (!done) chk("offer_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      done = (exp_q.size() == 0) && !fifo_full && !winc_pend;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Reset for n cycles; the FIFO model is refilled with fill_data if fill.
  task automatic do_reset(input int n, input logic fill, input logic [DW-1:0] fill_data,
                          input logic jump, input logic ready);
    @(posedge Clk); #1;
    mon_en       = 1'b0;
    Rst          = 1'b0;
    JumpFlag     = jump;
    OutReady     = ready;
    fifo_full    = fill;
    fifo_data    = fill_data;
    winc_pend    = 1'b0;
    rinc_s       = 1'b0;
    exp_q.delete();
    exp_drop     = 0;
    exp_drop_nxt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      chk("rst_rinc", {63'd0, FifoRInc}, 64'd0);
      if (i > 0) begin
        chk("rst_valid", {63'd0, OutValid}, 64'd0);
        chk("rst_data", OutData, 64'd0);
        chk("rst_drop", {56'd0, DropCnt}, 64'd0);
      end
      if (i < n - 1) begin
        @(posedge Clk); #1;
      end
    end
    @(posedge Clk); #1;
    Rst      = 1'b1;
    JumpFlag = 1'b0;
    OutReady = 1'b0;
    if (fifo_full) exp_q.push_back(fifo_data);
    mon_en = 1'b1;
    @(negedge Clk);
    rinc_s = FifoRInc;
  endtask

  // Monitor: expected behaviour derived from how many entries the stage holds
  // (queued entries not still sitting in the FIFO).
  always @(negedge Clk) begin
    int   held;
    logic exp_valid;
    logic exp_rinc;
    if (mon_en) begin
      held      = exp_q.size() - (fifo_full ? 1 : 0);
      exp_valid = !JumpFlag && (held > 0);
      exp_rinc  = fifo_full && (JumpFlag || (held < 2));
      chk("out_valid", {63'd0, OutValid}, {63'd0, exp_valid});
      chk("fifo_rinc", {63'd0, FifoRInc}, {63'd0, exp_rinc});
      chk("drop_cnt", {56'd0, DropCnt}, 64'(exp_drop));
      if (!JumpFlag) chk("held_le_2", {63'd0, held > 2}, 64'd0);
      if (exp_valid) begin
        chk("out_data", OutData, exp_q[0]);
        if (OutReady) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    Rst = 1'b0; JumpFlag = 1'b0; OutReady = 1'b0;
    fifo_full = 1'b1; fifo_data = 64'hA0;
    winc_pend = 1'b0; wpend_data = '0; rinc_s = 1'b0;
    exp_drop = 0; exp_drop_nxt = 0; mon_en = 1'b0;

    // Reset with a FIFO entry waiting; it must be popped right after release.
    do_reset(2, 1'b1, 64'hA0, 1'b0, 1'b0);
    drain();

    // Streaming with the consumer always ready.
    offer(64'hA1, 1'b1);
    offer(64'hA2, 1'b1);
    offer(64'hA3, 1'b1);
    drain();

    // Backpressure: two entries absorbed, third held in the FIFO.
    offer(64'h10, 1'b0);
    offer(64'h11, 1'b0);
    offer(64'h12, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, '0);
    chk("bp_fifo_held", {63'd0, FifoRInc}, 64'd0);
    drain();

    // Flush with a full buffer and full FIFO: three entries dropped.
    offer(64'h20, 1'b0);
    offer(64'h21, 1'b0);
    offer(64'h22, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("flush_drop3", {56'd0, DropCnt}, 64'd3);
    drain();

    // Simultaneous push and pop while holding one entry.
    offer(64'h5, 1'b0);
    offer(64'h6, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("pushpop_data", OutData, 64'h6);
    drain();

    // Randomized traffic with occasional redirects.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 9) < 6), {$urandom, $urandom});
    end
    drain();

    // Saturation: 90 flushes of three entries each.
    for (int k = 0; k < 90; k++) begin
      offer(64'(k * 3),     1'b0);
      offer(64'(k * 3 + 1), 1'b0);
      offer(64'(k * 3 + 2), 1'b0);
      step(1'b0, 1'b1, 1'b0, '0);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    chk("drop_sat", {56'd0, DropCnt}, 64'd255);
    offer(64'h77, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("drop_stays_sat", {56'd0, DropCnt}, 64'd255);

    // Mid-run reset with redirect and ready asserted: everything clears.
    offer(64'h88, 1'b0);
    offer(64'h99, 1'b0);
    do_reset(2, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("drop_after_rst", {56'd0, DropCnt}, 64'd0);
    offer(64'hB1, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_read_stage.md
# fifo_read_stage

Read-side drain stage for the one-deep synchronous pipeline FIFOs in the Balotelli core. It pops entries from a FIFO's read port (REmpty/RData/RInc), holds them in a 2-entry skid buffer, and presents them to the next pipeline stage over a valid/ready handshake. On a branch/jump redirect it flushes its own entries and the FIFO entry, and counts the discarded entries.

## Interface
- DataWidth, 64, payload width; must match the FIFO's DataWidth
- Clk  in  1  clock, all state updates on posedge
- Rst  in  1  reset, synchronous, active-low
- FifoRData  in  DataWidth  FIFO read data; valid while FifoREmpty=0
- FifoREmpty  in  1  FIFO empty flag
- FifoRInc  out  1  FIFO pop strobe; combinational; the pop takes effect at the next edge
- OutData  out  DataWidth  head entry of the skid buffer
- OutValid  out  1  head entry valid
- OutReady  in  1  downstream accepts the head this cycle
- JumpFlag  in  1  pipeline redirect; flushes the stage
- DropCnt  out  8  count of entries discarded by flushes; saturates at 255

## Operation
- Storage: Head and Tail registers (DataWidth each), plus a 2-bit state Count: EMPTY=0, ONE=1, TWO=2.
- Push = FifoRInc. Pop = OutValid && OutReady.
- FifoRInc:
  - Normal: !FifoREmpty && !JumpFlag && Count!=TWO.
  - Flush: JumpFlag && !FifoREmpty, so the FIFO entry is discarded.
  - Forced 0 while Rst=0.
- OutValid = (Count!=EMPTY) && !JumpFlag. No handshake completes in a flush cycle.
- OutData = Head, independent of OutValid.
- Transitions when JumpFlag=0:
  - EMPTY: push -> ONE, Head<=FifoRData.
  - ONE: push only -> TWO, Tail<=FifoRData.
  - ONE: pop only -> EMPTY.
  - ONE: push and pop -> ONE, Head<=FifoRData.
  - TWO: pop -> ONE, Head<=Tail. Push is never issued in TWO.
  - No push and no pop: hold.
- JumpFlag=1, any state: next Count=EMPTY. Head and Tail are don't-care and may hold stale values.
  - DropCnt += Count + (FifoREmpty ? 0 : 1), saturating at 255. Widen to 9 bits before the compare.
- Ordering: strict FIFO order. Head is always the oldest entry.
- Upstream rule: the writer must not assert WInc while WFull=1. WInc and RInc together leave the FIFO unchanged, so violating this produces a duplicate entry. The verification bench asserts this rule; the block does not check it.

## Timing
- Reset (Rst=0 at an edge): Count=EMPTY, Head=Tail=0, DropCnt=0.
  - Outputs after reset: OutValid=0, OutData=0, FifoRInc=0.
- Latency, FIFO to output: FIFO entry visible (FifoREmpty=0) at cycle t with Count=EMPTY gives FifoRInc=1 at t, then OutValid=1 and OutData=entry at t+1.
- FIFO refill is one entry per two cycles at most: the FIFO cannot write and read in the same cycle. Steady-state throughput is therefore 1 per 2 cycles, and the stage never stalls it while Count<TWO.
- Backpressure: with OutReady=0, the stage absorbs 2 entries, then drops FifoRInc.
  - OutReady rising at cycle t with Count=TWO: pop at t, Count=ONE at t+1, FifoRInc may assert at t+1.
- There is no combinational path from OutReady to FifoRInc.
- Flush: JumpFlag at cycle t gives OutValid=0 and FifoRInc=!FifoREmpty during t. At t+1: Count=EMPTY, DropCnt updated, FIFO empty.
- JumpFlag held for multiple cycles: each cycle flushes and counts whatever is present, so normally 0 after the first cycle.
- Reset asserted mid-operation: all state is cleared at that edge regardless of JumpFlag and OutReady. DropCnt is not incremented.

## Test plan
- Reset check: Rst=0 for 2 cycles with FifoREmpty=0 -> FifoRInc=0, OutValid=0, OutData=0, DropCnt=0. After release, FifoRInc=1 in the first cycle.
- Stream with OutReady=1: FIFO model fed 0xA1, 0xA2, 0xA3 -> OutData shows 0xA1, 0xA2, 0xA3 in order, each for one valid cycle, OutValid 1 cycle after each pop, no duplicates or losses.
- Backpressure: OutReady=0 while 3 entries are offered (0x10, 0x11, 0x12) -> Count reaches TWO, FifoRInc stays 0 with 0x12 held in the FIFO. Raise OutReady -> 0x10, 0x11, 0x12 delivered in order.
- Flush with full buffer: Count=TWO and FIFO full, JumpFlag for 1 cycle -> OutValid=0 that cycle, FifoRInc=1, next cycle Count=EMPTY and DropCnt=3.
- Simultaneous push and pop in ONE: Head=0x5, FIFO holds 0x6, OutReady=1 -> next cycle Count=ONE, OutData=0x6.
- Saturation: 90 flushes of 3 entries each -> DropCnt=255 and stays at 255. Then Rst=0 -> DropCnt=0.
